i2cm_seq: RTL and testbench
===========================

I2CM_SEQ -- requirements
Module: i2cm_seq

Interface
REQ-001 Parameter TMO_W, default 16: width of the per-command watchdog counter.
REQ-002 Parameter CMD_START/CMD_WRITE/CMD_READ/CMD_STOP, defaults 5'h01/5'h02/5'h04/5'h08: one-hot command codes shared with the I2C master core.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  transaction request.
REQ-006 req_ready  out  1  sequencer can accept a request.
REQ-007 req_wr  in  1  1 = register write, 0 = register read.
REQ-008 req_dev  in  7  7-bit slave address.
REQ-009 req_reg  in  8  slave register index.
REQ-010 req_wdata  in  8  write data byte.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_err  out  2  00 ok, 01 address NACK, 10 register/data NACK, 11 timeout.
REQ-013 rsp_rdata  out  8  read byte; valid with rsp_valid on a read with rsp_err=00.
REQ-014 cmds  out  5  command to core; at most one bit set.
REQ-015 cdone  in  5  one-cycle pulse from core naming the finished command.
REQ-016 tbyte  out  8  byte for the core to transmit.
REQ-017 txack  out  1  ack bit the core sends after a read.
REQ-018 rxack  in  1  slave ack bit; valid while cdone has the CMD_WRITE bit set.
REQ-019 rbyte  in  8  received byte; valid while cdone has the CMD_READ bit set.
REQ-020 clr_n  out  1  active-low synchronous abort to the core.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 States: IDLE, START, DEVW, REG, WDATA, RSTART, DEVR, READ, STOP, RESP.
REQ-023 req_ready = 1 only in IDLE; on req_valid & req_ready, latch req_wr/dev/reg/wdata, clear the latched error to 00, go START.
REQ-024 Each issuing state holds its one cmds bit registered high until the matching cdone bit is seen, then clears cmds at the next edge, so cmds is 0 for at least one cycle between commands.
REQ-025 tbyte per state: DEVW {dev,1'b0}; REG reg; WDATA wdata; DEVR {dev,1'b1}; otherwise 0.
REQ-026 Write sequence: START -> DEVW -> REG -> WDATA -> STOP -> RESP.
REQ-027 Read sequence: START -> DEVW -> REG -> RSTART -> DEVR -> READ -> STOP -> RESP; RSTART issues CMD_START.
REQ-028 txack = 1 (NACK) while in READ; rbyte is latched into rsp_rdata on the cdone CMD_READ cycle.
REQ-029 On the cdone CMD_WRITE cycle with rxack = 1: from DEVW or DEVR set error 01; from REG or WDATA set error 10; in all cases go STOP and skip the remaining bytes.
REQ-030 Watchdog: cleared on entry to each issuing state; increments each cycle while waiting for cdone; on reaching all-ones:
  - drive clr_n = 0 for exactly one cycle;
  - clear cmds;
  - set error 11;
  - go RESP without issuing STOP.
REQ-031 RESP: rsp_valid = 1 for one cycle with rsp_err and rsp_rdata, then IDLE; req_ready is 0 during RESP.
REQ-032 A cdone bit that does not match the current command is ignored.
REQ-033 rsp_rdata holds its value until the next successful read.

Reset
REQ-034 rst_n low at any time, including mid-transaction: state IDLE, cmds 0, tbyte 0, txack 0, clr_n 1, rsp_valid 0, rsp_err 00, rsp_rdata 00, busy 0, watchdog 0.
REQ-035 After reset release, req_ready = 1 in the first cycle.

Verification
REQ-036 Write dev 0x50, reg 0x10, data 0xA5; core model acks everything -> tbyte sequence 0xA0, 0x10, 0xA5; cmds START, W, W, W, STOP; one rsp_valid with err 00.
REQ-037 Read dev 0x50, reg 0x3C; model returns 0x5A -> tbyte 0xA0, 0x3C, 0xA1; cmds START, W, W, START, W, R, STOP; txack 1 during READ; rsp_rdata 0x5A, err 00.
REQ-038 Write with rxack = 1 on the address byte -> no REG/WDATA commands issued; STOP issued; err 01.
REQ-039 Read with rxack = 1 on the register byte -> no RSTART issued; STOP issued; err 10.
REQ-040 Core model never pulses cdone for START, TMO_W = 4 -> clr_n low one cycle after 15 waiting cycles; no STOP issued; err 11; sequencer back to IDLE.
REQ-041 Assert rst_n low while in READ -> all outputs at reset values immediately; the next request completes normally.

Source files
------------

// File: rtl/i2cm_seq_if.sv
// Request/response and core-command bundle between the I2C register
// sequencer, its requester and the I2C master core.
interface i2cm_seq_if;
  // requester side
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;
  // core side
  logic [4:0] cmds;
  logic [4:0] cdone;
  logic [7:0] tbyte;
  logic       txack;
  logic       rxack;
  logic [7:0] rbyte;
  logic       clr_n;
  logic       busy;

  // sequencer view
  modport slave (
    input  req_valid, req_wr, req_dev, req_reg, req_wdata, cdone, rxack, rbyte,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, cmds, tbyte, txack, clr_n, busy
  );

  // requester + core view
  modport master (
    output req_valid, req_wr, req_dev, req_reg, req_wdata, cdone, rxack, rbyte,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, cmds, tbyte, txack, clr_n, busy
  );
endinterface

// File: rtl/i2cm_seq.sv
// I2C register-access sequencer: turns one register read/write request into
// the START/byte/STOP command sequence for a byte-level I2C master core,
// with ack checking and a per-command watchdog.
module i2cm_seq #(
  parameter int         TMO_W     = 16,
  parameter logic [4:0] CMD_START = 5'h01,
  parameter logic [4:0] CMD_WRITE = 5'h02,
  parameter logic [4:0] CMD_READ  = 5'h04,
  parameter logic [4:0] CMD_STOP  = 5'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  i2cm_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEVW, S_REG, S_WDATA,
    S_RSTART, S_DEVR, S_READ, S_STOP, S_RESP
  } state_t;

  state_t           r_state;
  logic [4:0]       r_cmds;
  logic [7:0]       r_tbyte;
  logic             r_txack;
  logic             r_clr_n;
  logic             r_rsp_valid;
  logic [1:0]       r_err;
  logic [7:0]       r_rdata;
  logic             r_wr;
  logic [6:0]       r_dev;
  logic [7:0]       r_reg;
  logic [7:0]       r_wdata;
  logic [TMO_W-1:0] r_wdog;

  logic [4:0]       w_cmd;
  logic             w_issue;
  logic             w_hit;
  logic [TMO_W-1:0] w_wdog_nxt;
  logic             w_tmo;

  // command owned by each issuing state (0 for IDLE/RESP)
  always_comb begin
    w_cmd = 5'h00;
    case (r_state)
      S_START, S_RSTART:              w_cmd = CMD_START;
      S_DEVW, S_REG, S_WDATA, S_DEVR: w_cmd = CMD_WRITE;
      S_READ:                         w_cmd = CMD_READ;
      S_STOP:                         w_cmd = CMD_STOP;
      default:                        w_cmd = 5'h00;
    endcase
  end

  // cmds is dropped on completion and every exit, so an issuing state with
  // cmds low has not yet issued; completion only counts on the matching bit
  assign w_issue    = (w_cmd != 5'h00) && (r_cmds == 5'h00);
  assign w_hit      = |(bus.cdone & r_cmds);
  assign w_wdog_nxt = r_wdog + {{(TMO_W-1){1'b0}}, 1'b1};
  assign w_tmo      = &w_wdog_nxt;

  // sequencer FSM with all core/response outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmds      <= 5'h00;
      r_tbyte     <= 8'h00;
      r_txack     <= 1'b0;
      r_clr_n     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 2'b00;
      r_rdata     <= 8'h00;
      r_wr        <= 1'b0;
      r_dev       <= 7'h00;
      r_reg       <= 8'h00;
      r_wdata     <= 8'h00;
      r_wdog      <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_clr_n     <= 1'b1;
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_wr    <= bus.req_wr;
          r_dev   <= bus.req_dev;
          r_reg   <= bus.req_reg;
          r_wdata <= bus.req_wdata;
          r_err   <= 2'b00;
          r_tbyte <= 8'h00;
          r_state <= S_START;
        end
        S_RESP: r_state <= S_IDLE;
        default: begin
          if (w_issue) begin
            r_cmds <= w_cmd;
            r_wdog <= '0;
          end else if (w_hit) begin
            r_cmds  <= 5'h00;
            r_wdog  <= '0;
            r_tbyte <= 8'h00;
            r_txack <= 1'b0;
            case (r_state)
              S_START: begin
                r_tbyte <= {r_dev, 1'b0};
                r_state <= S_DEVW;
              end
              S_DEVW: if (bus.rxack) begin
                r_err   <= 2'b01;
                r_state <= S_STOP;
              end else begin
                r_tbyte <= r_reg;
                r_state <= S_REG;
              end
              S_REG: if (bus.rxack) begin
                r_err   <= 2'b10;
                r_state <= S_STOP;
              end else if (r_wr) begin
                r_tbyte <= r_wdata;
                r_state <= S_WDATA;
              end else begin
                r_state <= S_RSTART;
              end
              S_WDATA: begin
                if (bus.rxack) r_err <= 2'b10;
                r_state <= S_STOP;
              end
              S_RSTART: begin
                r_tbyte <= {r_dev, 1'b1};
                r_state <= S_DEVR;
              end
              S_DEVR: if (bus.rxack) begin
                r_err   <= 2'b01;
                r_state <= S_STOP;
              end else begin
                r_txack <= 1'b1;
                r_state <= S_READ;
              end
              S_READ: begin
                r_rdata <= bus.rbyte;
                r_state <= S_STOP;
              end
              default: begin
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end
            endcase
          end else if (w_tmo) begin
            // core hung: abort it and report without a STOP
            r_cmds      <= 5'h00;
            r_wdog      <= w_wdog_nxt;
            r_tbyte     <= 8'h00;
            r_txack     <= 1'b0;
            r_clr_n     <= 1'b0;
            r_err       <= 2'b11;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wdog <= w_wdog_nxt;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.cmds      = r_cmds;
  assign bus.tbyte     = r_tbyte;
  assign bus.txack     = r_txack;
  assign bus.clr_n     = r_clr_n;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_i2cm_seq.sv
// Bench for i2cm_seq: a randomized I2C core model answers commands, a monitor
// logs the issued command/byte stream, and each transaction is compared with
// the sequence predicted from the register-access protocol.
module tb_i2cm_seq;
  localparam logic [4:0] C_S = 5'h01, C_W = 5'h02, C_R = 5'h04, C_P = 5'h08;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2cm_seq_if bi();
  i2cm_seq #(.TMO_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bi));

  int checks = 0;
  int errors = 0;

  // core model configuration
  int   m_nack_k = 0;   // 1-based index of the CMD_WRITE to NACK, 0 = none
  bit   m_tmo    = 0;   // never complete CMD_START
  bit   m_spur   = 0;   // inject non-matching cdone pulses while waiting
  logic [7:0] m_rbyte = 8'h00;
  int   m_wr_cnt = 0;

  // monitor logs
  logic [12:0] cmd_q[$];
  int n_rsp = 0, n_clr_lo = 0, n_start_hi = 0, n_proto_bad = 0;
  logic [4:0] prev_cmds = 5'h00;

  // reference expectations
  logic [12:0] exp_q[$];
  logic [1:0]  exp_err;
  logic [7:0]  exp_rdata;
  logic [7:0]  last_rdata = 8'h00;

  // core model: answers each command after 0..3 cycles
  initial begin
    bit fired;
    int wcnt;
    fired = 0; wcnt = -1;
    bi.cdone = 5'h00; bi.rxack = 1'b0; bi.rbyte = 8'h00;
    forever begin
      @(posedge clk); #1;
      bi.cdone = 5'h00; bi.rxack = 1'b0;
      if (!rst_n || bi.cmds == 5'h00) begin
        fired = 0; wcnt = -1;
      end else if (!fired) begin
        if (wcnt < 0) wcnt = $urandom_range(3, 0);
        if (wcnt == 0) begin
          if (!(m_tmo && bi.cmds == C_S)) begin
            bi.cdone = bi.cmds;
            fired = 1;
            if (bi.cmds == C_W) begin
              m_wr_cnt++;
              bi.rxack = (m_wr_cnt == m_nack_k);
            end
            if (bi.cmds == C_R) bi.rbyte = m_rbyte;
          end
        end else begin
          wcnt--;
          if (m_spur && $urandom_range(2, 0) == 0) begin
            bi.cdone = (bi.cmds == C_P) ? C_W : C_P;
            bi.rxack = 1'b1;
          end
        end
      end
    end
  end

  // monitor: command stream and protocol counters
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bi.cmds != 5'h00 && prev_cmds == 5'h00) cmd_q.push_back({bi.cmds, bi.tbyte});
      if (bi.cmds != 5'h00 && prev_cmds != 5'h00 && bi.cmds != prev_cmds) n_proto_bad++;
      if ($countones(bi.cmds) > 1) n_proto_bad++;
      if (bi.cmds == C_R && !bi.txack) n_proto_bad++;
      if (bi.cmds == C_S) n_start_hi++;
      if (!bi.clr_n) n_clr_lo++;
      if (bi.rsp_valid) n_rsp++;
      prev_cmds = bi.cmds;
    end
  end

  // protocol-level prediction of one transaction
  task automatic predict(input bit wr, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input int nk, input bit tmo,
                         input logic [7:0] rb);
    logic [7:0] b[3];
    exp_q = {};
    exp_err = 2'b00;
    exp_rdata = last_rdata;
    exp_q.push_back({C_S, 8'h00});
    if (tmo) begin
      exp_err = 2'b11;
      return;
    end
    b[0] = {dev, 1'b0};
    b[1] = rg;
    b[2] = wr ? wd : {dev, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (!wr && i == 2) exp_q.push_back({C_S, 8'h00});
      exp_q.push_back({C_W, b[i]});
      if (nk == i + 1) begin
        exp_err = (i == 1 || (wr && i == 2)) ? 2'b10 : 2'b01;
        break;
      end
    end
    if (!wr && nk == 0) begin
      exp_q.push_back({C_R, 8'h00});
      exp_rdata = rb;
      last_rdata = rb;
    end
    exp_q.push_back({C_P, 8'h00});
  endtask

  task automatic run_txn(input string nm, input bit wr, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd, input int nk,
                         input bit tmo, input logic [7:0] rb);
    int n;
    logic [1:0] g_err;
    logic [7:0] g_rd;
    logic       g_rdy, g_clr;
    predict(wr, dev, rg, wd, nk, tmo, rb);
    m_nack_k = nk; m_tmo = tmo; m_rbyte = rb; m_wr_cnt = 0;
    n = 0;
    while (!bi.req_ready && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (!bi.req_ready) begin
      errors++; $display("FAIL %s req_ready got 0 want 1", nm); return;
    end
    cmd_q = {}; n_rsp = 0; n_clr_lo = 0; n_start_hi = 0; n_proto_bad = 0;
    bi.req_wr = wr; bi.req_dev = dev; bi.req_reg = rg; bi.req_wdata = wd;
    bi.req_valid = 1'b1;
    @(posedge clk); #1;
    bi.req_valid = 1'b0;
    n = 0;
    while (!bi.rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
    checks++;
    if (!bi.rsp_valid) begin
      errors++; $display("FAIL %s rsp_valid timed out after %0d cycles", nm, n); return;
    end
    g_err = bi.rsp_err; g_rd = bi.rsp_rdata; g_rdy = bi.req_ready; g_clr = bi.clr_n;
    @(posedge clk); #1;
    checks++;
    if (g_err !== exp_err) begin errors++; $display("FAIL %s rsp_err got %0d want %0d", nm, g_err, exp_err); end
    checks++;
    if (g_rd !== exp_rdata) begin errors++; $display("FAIL %s rsp_rdata got %h want %h", nm, g_rd, exp_rdata); end
    checks++;
    if (g_rdy !== 1'b0) begin errors++; $display("FAIL %s req_ready in RESP got %b want 0", nm, g_rdy); end
    checks++;
    if (n_rsp !== 1 || bi.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s rsp pulses got %0d ready %b want 1 1", nm, n_rsp, bi.req_ready);
    end
    checks++;
    if (n_proto_bad !== 0) begin errors++; $display("FAIL %s protocol violations got %0d want 0", nm, n_proto_bad); end
    checks++;
    if (cmd_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s cmd count got %0d want %0d", nm, cmd_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (cmd_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s cmd[%0d] got cmd %h byte %h want cmd %h byte %h", nm, i,
                   cmd_q[i][12:8], cmd_q[i][7:0], exp_q[i][12:8], exp_q[i][7:0]);
          break;
        end
      end
    end
    checks++;
    if (n_clr_lo !== (tmo ? 1 : 0)) begin errors++; $display("FAIL %s clr_n low cycles got %0d want %0d", nm, n_clr_lo, tmo ? 1 : 0); end
    if (tmo) begin
      checks++;
      if (n_start_hi !== 15 || g_clr !== 1'b0) begin
        errors++; $display("FAIL %s watchdog START cycles got %0d clr_n %b want 15 0", nm, n_start_hi, g_clr);
      end
    end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if (bi.cmds !== 5'h00 || bi.tbyte !== 8'h00 || bi.txack !== 1'b0 || bi.clr_n !== 1'b1 ||
        bi.rsp_valid !== 1'b0 || bi.rsp_err !== 2'b00 || bi.rsp_rdata !== 8'h00 ||
        bi.busy !== 1'b0 || dut.r_wdog !== 4'h0) begin
      errors++;
      $display("FAIL %s outputs got cmds %h tbyte %h txack %b clr_n %b rv %b err %0d rd %h busy %b want 00 00 0 1 0 0 00 0",
               nm, bi.cmds, bi.tbyte, bi.txack, bi.clr_n, bi.rsp_valid, bi.rsp_err, bi.rsp_rdata, bi.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    #1;
    checks++;
    if (bi.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bi.req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_txn("write", 1'b1, 7'h50, 8'h10, 8'hA5, 0, 1'b0, 8'h00);
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, 7'h50, 8'h3C, 8'h00, 0, 1'b0, 8'h5A);
  endtask

  task automatic test_addr_nack();
    run_txn("addr_nack", 1'b1, 7'h50, 8'h10, 8'hA5, 1, 1'b0, 8'h00);
  endtask

  task automatic test_reg_nack();
    run_txn("reg_nack", 1'b0, 7'h50, 8'h3C, 8'h00, 2, 1'b0, 8'h77);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b1, 7'h22, 8'h01, 8'h02, 0, 1'b1, 8'h00);
  endtask

  task automatic test_reset_mid();
    int n;
    m_nack_k = 0; m_tmo = 0; m_rbyte = 8'hC3; m_wr_cnt = 0;
    bi.req_wr = 1'b0; bi.req_dev = 7'h33; bi.req_reg = 8'h44; bi.req_wdata = 8'h00;
    bi.req_valid = 1'b1;
    @(posedge clk); #1;
    bi.req_valid = 1'b0;
    n = 0;
    while (bi.cmds !== C_R && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (bi.cmds !== C_R) begin errors++; $display("FAIL reset_mid READ not reached got cmds %h", bi.cmds); end
    rst_n = 1'b0;
    #1;
    last_rdata = 8'h00;
    check_reset_vals("reset_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bi.req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %b want 1", bi.req_ready); end
    @(posedge clk); #1;
    run_txn("after_reset", 1'b0, 7'h33, 8'h44, 8'h00, 0, 1'b0, 8'h96);
  endtask

  task automatic test_random();
    int nk;
    bit wr;
    m_spur = 1;
    for (int t = 0; t < 24; t++) begin
      wr = $urandom_range(1, 0);
      nk = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3, 1);
      run_txn("random", wr, 7'($urandom), 8'($urandom), 8'($urandom), nk, 1'b0, 8'($urandom));
    end
    m_spur = 0;
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_w", 1'b1, 7'h7F, 8'hFF, 8'h00, 0, 1'b0, 8'h00);
    run_txn("b2b_r", 1'b0, 7'h00, 8'h00, 8'h00, 0, 1'b0, 8'hFF);
    run_txn("b2b_dnack", 1'b0, 7'h01, 8'h02, 8'h00, 3, 1'b0, 8'h11);
  endtask

  initial begin
    bi.req_valid = 1'b0; bi.req_wr = 1'b0; bi.req_dev = 7'h00;
    bi.req_reg = 8'h00; bi.req_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_reg_nack();
    test_timeout();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
